// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared access-size encodings and datapath width for the MEM stage.
package mem_stage_pkg;
  localparam int DW = 32;
  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_HALF = 2'b01,
    MEM_BYTE = 2'b10,
    MEM_RSVD = 2'b11
  } mem_type_e;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: execute-stage inputs and M/W-stage outputs of the memory pipeline stage.
interface mem_stage_if;
  import mem_stage_pkg::*;
  logic [DW-1:0] ALUResultE, WriteDataE;
  logic [4:0]    WriteRegE;
  logic          RegWriteE, MemReadE, MemWriteE, MemToRegE, MemSignedE, FlushE;
  logic [1:0]    MemTypeE;
  logic [DW-1:0] ALUResultM, ReadData2M, MemReadDataM;
  logic [4:0]    WriteRegM;
  logic [1:0]    MemTypeM;
  logic          MemReadM, RegWriteM, MisalignM;
  logic [DW-1:0] ALUResultW, MemReadDataW, WriteDataW;
  logic [4:0]    WriteRegW;
  logic          RegWriteW;
  modport master (
    output ALUResultE, WriteDataE, WriteRegE, RegWriteE, MemReadE, MemWriteE,
           MemToRegE, MemSignedE, FlushE, MemTypeE,
    input  ALUResultM, ReadData2M, MemReadDataM, WriteRegM, MemTypeM, MemReadM,
           RegWriteM, MisalignM, ALUResultW, MemReadDataW, WriteDataW, WriteRegW, RegWriteW
  );
  modport slave (
    input  ALUResultE, WriteDataE, WriteRegE, RegWriteE, MemReadE, MemWriteE,
           MemToRegE, MemSignedE, FlushE, MemTypeE,
    output ALUResultM, ReadData2M, MemReadDataM, WriteRegM, MemTypeM, MemReadM,
           RegWriteM, MisalignM, ALUResultW, MemReadDataW, WriteDataW, WriteRegW, RegWriteW
  );
endinterface

// File: rtl/mem_stage_data_mem.sv
// data_mem: DEPTH x 32-bit words, byte-enable synchronous write, combinational read; contents never reset.
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [3:0]               i_be,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DW-1:0]            i_wdata,
  output logic [DW-1:0]            o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (i_be[i]) r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM + MEM/WB pipeline registers around a big-endian byte-addressable data memory.
// Optional MEM_ALIGN_CHECK_EN flags misaligned half/word accesses and suppresses them.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic Clk,
  input  logic Reset,
  mem_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] r_alu_m, r_wd_m, r_rd_w, r_alu_w;
  logic [4:0]    r_wreg_m, r_wreg_w;
  logic [1:0]    r_type_m;
  logic          r_regwrite_m, r_memread_m, r_memwrite_m, r_memtoreg_m, r_signed_m;
  logic          r_regwrite_w, r_memtoreg_w;
  logic [DW-1:0] w_word, w_wdata, w_load, w_rd;
  logic [3:0]    w_be;
  logic [1:0]    w_off;
  logic [7:0]    w_b;
  logic [15:0]   w_h;
  logic          w_half, w_byte, w_mis, w_we;
  assign w_half = r_type_m == MEM_HALF;
  assign w_byte = r_type_m == MEM_BYTE;
`ifdef MEM_ALIGN_CHECK_EN
  assign w_mis = (r_memread_m | r_memwrite_m) &
                 (w_half ? r_alu_m[0] : !w_byte && r_alu_m[1:0] != 2'b00);
`else
  assign w_mis = 1'b0;
`endif
  // Offset bits below the access size are dropped, forcing alignment; reserved type acts as word.
  assign w_off   = w_byte ? r_alu_m[1:0] : w_half ? {r_alu_m[1], 1'b0} : 2'b00;
  assign w_b     = 8'(w_word >> {~w_off, 3'b000});
  assign w_h     = w_off[1] ? w_word[15:0] : w_word[31:16];
  assign w_load  = w_byte ? {{24{r_signed_m & w_b[7]}}, w_b} :
                   w_half ? {{16{r_signed_m & w_h[15]}}, w_h} : w_word;
  assign w_rd    = r_memread_m && !w_mis ? w_load : '0;
  assign w_be    = w_byte ? 4'b1000 >> w_off : w_half ? (w_off[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign w_wdata = w_byte ? {4{r_wd_m[7:0]}} : w_half ? {2{r_wd_m[15:0]}} : r_wd_m;
  assign w_we    = r_memwrite_m & ~Reset & ~w_mis;
  data_mem #(.DEPTH(DEPTH)) u_mem (
    .clk    (Clk),
    .i_be   (w_be & {4{w_we}}),
    .i_addr (r_alu_m[AW+1:2]),
    .i_wdata(w_wdata),
    .o_rdata(w_word)
  );
  always_ff @(posedge Clk) begin
    if (Reset) begin
      {r_alu_m, r_wd_m, r_wreg_m, r_type_m, r_regwrite_m, r_memread_m, r_memwrite_m,
       r_memtoreg_m, r_signed_m} <= '0;
      {r_rd_w, r_alu_w, r_wreg_w, r_regwrite_w, r_memtoreg_w} <= '0;
    end else begin
      r_alu_m      <= bus.ALUResultE;
      r_wd_m       <= bus.WriteDataE;
      r_wreg_m     <= bus.WriteRegE;
      r_type_m     <= bus.MemTypeE;
      r_signed_m   <= bus.MemSignedE;
      r_regwrite_m <= bus.RegWriteE & ~bus.FlushE;
      r_memread_m  <= bus.MemReadE & ~bus.FlushE;
      r_memwrite_m <= bus.MemWriteE & ~bus.FlushE;
      r_memtoreg_m <= bus.MemToRegE & ~bus.FlushE;
      r_rd_w       <= w_rd;
      r_alu_w      <= r_alu_m;
      r_wreg_w     <= r_wreg_m;
      r_regwrite_w <= r_regwrite_m & ~(w_mis & r_memread_m);
      r_memtoreg_w <= r_memtoreg_m;
    end
  end
  assign bus.ALUResultM   = r_alu_m;
  assign bus.ReadData2M   = r_wd_m;
  assign bus.MemReadDataM = w_rd;
  assign bus.WriteRegM    = r_wreg_m;
  assign bus.MemTypeM     = r_type_m;
  assign bus.MemReadM     = r_memread_m;
  assign bus.RegWriteM    = r_regwrite_m;
  assign bus.MisalignM    = w_mis;
  assign bus.ALUResultW   = r_alu_w;
  assign bus.MemReadDataW = r_rd_w;
  assign bus.WriteDataW   = r_memtoreg_w ? r_rd_w : r_alu_w;
  assign bus.WriteRegW    = r_wreg_w;
  assign bus.RegWriteW    = r_regwrite_w;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: transaction-level model with a byte-array memory, per-cycle compare plus literal checks.
module tb_mem_stage;
  localparam int DEPTH = 64;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif
  logic clk = 0, rst = 1, live = 0;
  int checks = 0, failures = 0;
  mem_stage_if bus();
  mem_stage #(.DEPTH(DEPTH)) dut (.Clk(clk), .Reset(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu, wd; logic [4:0] wreg; logic [1:0] ty; logic rw, rd, wr, m2r, sg;
  } m_t;
  typedef struct packed { logic [31:0] rdv, alu; logic [4:0] wreg; logic rw, m2r; } w_t;
  m_t mq = '0;
  w_t wq = '0;
  logic [7:0] mb [DEPTH*4];

  function automatic int sz(logic [1:0] t);
    return t == 2'b01 ? 2 : t == 2'b10 ? 1 : 4;
  endfunction
  function automatic int base(logic [31:0] a, logic [1:0] t);
    return int'((a >> 2) % DEPTH) * 4 + int'(a % 4) / sz(t) * sz(t);
  endfunction
  function automatic bit mis(m_t t);
    return ALN && (t.rd || t.wr) && (t.alu % sz(t.ty)) != 0;
  endfunction
  function automatic logic [31:0] ld(m_t t);
    logic [31:0] v = 0;
    int b = base(t.alu, t.ty), n = sz(t.ty);
    if (!t.rd || mis(t)) return 0;
    for (int k = 0; k < n; k++) v = (v << 8) | 32'(mb[b+k]);
    if (t.sg && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
    return v;
  endfunction

  task automatic chk(string n, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", n, got, exp, $time);
    end
  endtask

  initial begin
    foreach (mb[i]) mb[i] = 8'h00;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq = '0; wq = '0;
      end else begin
        w_t nw;
        int b, n;
        nw = '{rdv: ld(mq), alu: mq.alu, wreg: mq.wreg, rw: mq.rw && !(mis(mq) && mq.rd), m2r: mq.m2r};
        if (mq.wr && !mis(mq)) begin
          b = base(mq.alu, mq.ty); n = sz(mq.ty);
          for (int k = 0; k < n; k++) mb[b+k] = mq.wd[8*(n-1-k) +: 8];
        end
        wq = nw;
        mq = '{alu: bus.ALUResultE, wd: bus.WriteDataE, wreg: bus.WriteRegE, ty: bus.MemTypeE,
               rw: bus.RegWriteE, rd: bus.MemReadE, wr: bus.MemWriteE, m2r: bus.MemToRegE,
               sg: bus.MemSignedE};
        if (bus.FlushE) {mq.rw, mq.rd, mq.wr, mq.m2r} = 4'b0000;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (live) begin
      chk("m_stage", {bus.ALUResultM, bus.ReadData2M, bus.MemReadDataM, bus.WriteRegM, bus.MemTypeM,
                      bus.MemReadM, bus.RegWriteM, bus.MisalignM},
                     {mq.alu, mq.wd, ld(mq), mq.wreg, mq.ty, mq.rd, mq.rw, mis(mq)});
      chk("w_stage", {bus.ALUResultW, bus.MemReadDataW, bus.WriteDataW, bus.WriteRegW, bus.RegWriteW},
                     {wq.alu, wq.rdv, wq.m2r ? wq.rdv : wq.alu, wq.wreg, wq.rw});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic op(logic rw, logic rd, logic wr, logic m2r, logic sg, logic [1:0] ty,
                    logic [31:0] a, logic [31:0] d, logic [4:0] rg, logic fl);
    bus.RegWriteE = rw; bus.MemReadE = rd; bus.MemWriteE = wr; bus.MemToRegE = m2r;
    bus.MemSignedE = sg; bus.MemTypeE = ty; bus.ALUResultE = a; bus.WriteDataE = d;
    bus.WriteRegE = rg; bus.FlushE = fl;
    tick();
  endtask
  task automatic st(logic [31:0] a, logic [31:0] d, logic [1:0] ty);
    op(0, 0, 1, 0, 0, ty, a, d, 5'd0, 0);
  endtask
  task automatic lo(logic [31:0] a, logic [1:0] ty, logic sg);
    op(1, 1, 0, 1, sg, ty, a, 32'd0, 5'd7, 0);
  endtask
  task automatic nop();
    op(0, 0, 0, 0, 0, 2'b00, 32'd0, 32'd0, 5'd0, 0);
  endtask

  initial begin
    rst = 1;
    nop();
    live = 1;
    chk("reset_w", {bus.WriteDataW, bus.ALUResultW, bus.MemReadDataW, bus.WriteRegW, bus.RegWriteW}, 0);
    rst = 0;
    for (int i = 0; i < DEPTH; i++) st(32'(i * 4), $urandom, 2'b00);
    st(32'h10, 32'h11223344, 2'b00);
    lo(32'h10, 2'b00, 0);
    nop();
    chk("sw_lw_data", bus.WriteDataW, 32'h11223344);
    chk("sw_lw_rw", bus.RegWriteW, 1);
    st(32'h11, 32'h000000AA, 2'b10);
    lo(32'h11, 2'b10, 0);
    lo(32'h11, 2'b10, 1);
    chk("lbu", bus.WriteDataW, 32'h000000AA);
    lo(32'h10, 2'b00, 0);
    chk("lb", bus.WriteDataW, 32'hFFFFFFAA);
    nop();
    chk("lw_after_sb", bus.WriteDataW, 32'h11AA3344);
    st(32'h12, 32'h00008001, 2'b01);
    lo(32'h12, 2'b01, 1);
    lo(32'h12, 2'b01, 0);
    chk("lh", bus.WriteDataW, 32'hFFFF8001);
    nop();
    chk("lhu", bus.WriteDataW, 32'h00008001);
    st(32'h20, 32'h55667788, 2'b00);
    op(1, 0, 1, 0, 0, 2'b00, 32'h20, 32'hDEADBEEF, 5'd5, 1);
    nop();
    chk("flush_rw", bus.RegWriteW, 0);
    lo(32'h20, 2'b00, 0);
    nop();
    chk("flush_mem", bus.WriteDataW, 32'h55667788);
    lo(32'h22, 2'b00, 0);
    chk("misalign_m", bus.MisalignM, ALN);
    nop();
    chk("lw22_rw", bus.RegWriteW, !ALN);
    chk("lw22_data", bus.WriteDataW, ALN ? 32'h0 : 32'h55667788);
    st(32'h10 + DEPTH * 4, 32'h99887766, 2'b00);
    lo(32'h10, 2'b00, 0);
    nop();
    chk("wrap", bus.WriteDataW, 32'h99887766);
    st(32'h30, 32'h0BADF00D, 2'b00);
    st(32'h30, 32'hCAFEF00D, 2'b00);
    rst = 1;
    nop();
    chk("rst_w", {bus.WriteDataW, bus.ALUResultW, bus.MemReadDataW, bus.WriteRegW, bus.RegWriteW}, 0);
    chk("rst_m", {bus.ALUResultM, bus.ReadData2M, bus.MemReadDataM, bus.WriteRegM, bus.MemTypeM,
                  bus.MemReadM, bus.RegWriteM, bus.MisalignM}, 0);
    rst = 0;
    lo(32'h30, 2'b00, 0);
    nop();
    chk("rst_mem", bus.WriteDataW, 32'h0BADF00D);
    for (int i = 0; i < 800; i++) begin
      rst = $urandom_range(0, 99) == 0;
      op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
         $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 255)), $urandom,
         5'($urandom), $urandom_range(0, 9) == 0);
    end
    rst = 0;
    nop();
    nop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
